// File: rtl/apb_if.sv
// APB bus bundle between the peripheral sequencer (master) and its slaves.
// PRDATA is flattened: slave i drives bits [32i+31:32i].
interface apb_if #(
  parameter int NUM_SLAVES = 4
) ();
  logic [NUM_SLAVES-1:0]    PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [31:0]              PADDR;
  logic [31:0]              PWDATA;
  logic [32*NUM_SLAVES-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;
  logic [NUM_SLAVES-1:0]    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_periph_ctrl.sv
// Turns a single-cycle core's lw/sw into the peripheral window into one APB
// transfer, stalling the core until the transfer completes or is aborted.
module apb_periph_ctrl #(
  parameter logic [31:0] PERIPH_BASE = 32'h0001_0000,
  parameter logic [31:0] PERIPH_MASK = 32'hFFFF_0000,
  parameter int          SLV_LSB     = 8,
  parameter int          NUM_SLAVES  = 4,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        cancel_data_memory,
  output logic        stall,
  output logic [31:0] periph_rdata,
  output logic        bus_err,
  apb_if.master       apb
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                  state_reg;
  logic [1:0]              idx_reg;
  logic [CNT_W-1:0]        wait_cnt_reg;

  logic                    hit;
  logic                    req;
  logic [1:0]              addr_idx;
  logic                    idx_valid;
  logic [NUM_SLAVES-1:0]   addr_onehot;
  logic [31:0]             sel_rdata;
  logic                    sel_ready;
  logic                    sel_err;

  assign hit       = (addr & PERIPH_MASK) == PERIPH_BASE;
  assign req       = (mem_read | mem_write) & hit;
  assign addr_idx  = addr[SLV_LSB+1:SLV_LSB];
  assign idx_valid = int'(addr_idx) < NUM_SLAVES;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_onehot
      assign addr_onehot[gi] = (addr_idx == 2'(gi));
    end
  endgenerate

  // Only the latched slave's response is looked at; the others are don't-care.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_reg == 2'(i)) begin
        sel_rdata = apb.PRDATA[32*i +: 32];
        sel_ready = apb.PREADY[i];
        sel_err   = apb.PSLVERR[i];
      end
    end
  end

  assign cancel_data_memory = req;
  // Gated by reset so an in-flight instruction is released while the core resets.
  assign stall = rst_n & (((state_reg == IDLE) & req) |
                          (state_reg == SETUP) | (state_reg == ACCESS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      apb.PSEL     <= '0;
      apb.PENABLE  <= 1'b0;
      apb.PWRITE   <= 1'b0;
      apb.PADDR    <= '0;
      apb.PWDATA   <= '0;
      periph_rdata <= '0;
      bus_err      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            apb.PWRITE <= mem_write;
            apb.PADDR  <= addr;
            apb.PWDATA <= wdata;
            idx_reg    <= addr_idx;
            if (idx_valid) begin
              apb.PSEL  <= addr_onehot;
              state_reg <= SETUP;
            end else begin
              periph_rdata <= '0;
              bus_err      <= 1'b1;
              state_reg    <= DONE;
            end
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            periph_rdata <= apb.PWRITE ? 32'h0 : sel_rdata;
            bus_err      <= sel_err;
            apb.PSEL     <= '0;
            apb.PENABLE  <= 1'b0;
            state_reg    <= DONE;
          end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            wait_cnt_reg <= CNT_W'(TIMEOUT);
            periph_rdata <= '0;
            bus_err      <= 1'b1;
            apb.PSEL     <= '0;
            apb.PENABLE  <= 1'b0;
            state_reg    <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          bus_err      <= 1'b0;
          wait_cnt_reg <= '0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_ctrl.sv
// Directed bench: drives core-side lw/sw, models three APB slaves with
// configurable wait states, and scoreboards each transfer's completion.
module tb_apb_periph_ctrl;
  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        cancel_data_memory, stall, bus_err;
  logic [31:0] periph_rdata;

  apb_if #(.NUM_SLAVES(NS)) bus ();

  apb_periph_ctrl #(.NUM_SLAVES(NS), .TIMEOUT(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .addr               (addr),
    .wdata              (wdata),
    .cancel_data_memory (cancel_data_memory),
    .stall              (stall),
    .periph_rdata       (periph_rdata),
    .bus_err            (bus_err),
    .apb                (bus)
  );

  always #5 clk = ~clk;

  // Slave models: ready after wait_cfg ACCESS cycles; unselected lines carry noise.
  int          wait_cfg [NS];
  logic [31:0] slv_data [NS];
  logic        slv_err  [NS];
  int          wcnt     [NS];
  logic        noise = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slv
      assign bus.PREADY[gi]  = (bus.PSEL[gi] && bus.PENABLE) ? (wcnt[gi] >= wait_cfg[gi]) : noise;
      assign bus.PSLVERR[gi] = (bus.PSEL[gi] && bus.PENABLE) ? slv_err[gi] : noise;
      assign bus.PRDATA[32*gi +: 32] = slv_data[gi];
      always @(posedge clk) begin
        if (bus.PSEL[gi] && bus.PENABLE && !bus.PREADY[gi]) wcnt[gi] <= wcnt[gi] + 1;
        else wcnt[gi] <= 0;
      end
    end
  endgenerate

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;
  exp_t sb [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One core memory instruction, presented at a negedge and held until retire.
  task automatic xact(input string name, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int exp_stalls, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic [2:0] exp_psel,
                      input logic exp_cancel);
    exp_t e;
    int   stalls;
    int   cyc;
    sb.push_back('{rdata: exp_rdata, err: exp_err, stalls: exp_stalls});
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    #1;
    chk({name, ".cancel"}, 32'(cancel_data_memory), 32'(exp_cancel));
    chk({name, ".err_idle"}, 32'(bus_err), 32'h0);
    stalls = 0;
    cyc = 0;
    while (stall === 1'b1 && cyc < 40) begin
      stalls++;
      if (cyc == 0) begin
        chk({name, ".psel_T"}, 32'(bus.PSEL), 32'h0);
      end else begin
        chk({name, ".psel"},    32'(bus.PSEL), 32'(exp_psel));
        chk({name, ".penable"}, 32'(bus.PENABLE), 32'(cyc > 1));
        chk({name, ".paddr"},   bus.PADDR, a);
        chk({name, ".pwdata"},  bus.PWDATA, wd);
        chk({name, ".pwrite"},  32'(bus.PWRITE), 32'(wr));
      end
      @(negedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({name, ".stalls"}, 32'(stalls), 32'(e.stalls));
    chk({name, ".psel_done"}, 32'(bus.PSEL), 32'h0);
    chk({name, ".penable_done"}, 32'(bus.PENABLE), 32'h0);
    if (e.stalls > 0) begin
      chk({name, ".rdata"},   periph_rdata, e.rdata);
      chk({name, ".bus_err"}, 32'(bus_err), 32'(e.err));
      chk({name, ".cancel_done"}, 32'(cancel_data_memory), 32'h1);
    end else begin
      @(negedge clk); #1;
      chk({name, ".miss_psel"},  32'(bus.PSEL), 32'h0);
      chk({name, ".miss_stall"}, 32'(stall), 32'h0);
    end
    $display("xact %-8s addr=%h wr=%0d stalls=%0d rdata=%h err=%0d", name, a, wr, stalls,
             periph_rdata, bus_err);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; slv_data[i] = 32'h0; slv_err[i] = 1'b0;
    end
    rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0001_0100; wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall",   32'(stall), 32'h0);
    chk("rst.psel",    32'(bus.PSEL), 32'h0);
    chk("rst.penable", 32'(bus.PENABLE), 32'h0);
    chk("rst.pwrite",  32'(bus.PWRITE), 32'h0);
    chk("rst.paddr",   bus.PADDR, 32'h0);
    chk("rst.pwdata",  bus.PWDATA, 32'h0);
    chk("rst.rdata",   periph_rdata, 32'h0);
    chk("rst.bus_err", 32'(bus_err), 32'h0);
    $display("xact reset   checked");
    @(negedge clk);
    mem_read = 1'b0;
    rst_n = 1'b1;

    noise = 1'b1;
    xact("sw_zw", 1'b0, 1'b1, 32'h0001_0104, 32'hA5A5_0001, 3, 32'h0, 1'b0, 3'b010, 1'b1);

    wait_cfg[2] = 3; slv_data[2] = 32'h1234_5678;
    xact("lw_w3", 1'b1, 1'b0, 32'h0001_0200, 32'h0, 6, 32'h1234_5678, 1'b0, 3'b100, 1'b1);

    // Reset asserted mid-ACCESS drops the transfer immediately.
    wait_cfg[2] = 10;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0001_0200;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.psel",    32'(bus.PSEL), 32'h0);
    chk("midrst.penable", 32'(bus.PENABLE), 32'h0);
    chk("midrst.stall",   32'(stall), 32'h0);
    chk("midrst.rdata",   periph_rdata, 32'h0);
    chk("midrst.paddr",   bus.PADDR, 32'h0);
    $display("xact midrst  checked");
    @(negedge clk);
    mem_read = 1'b0;
    rst_n = 1'b1;
    wait_cfg[2] = 0; slv_data[2] = 32'h0BAD_F00D;
    xact("lw_post", 1'b1, 1'b0, 32'h0001_0200, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 3'b100, 1'b1);

    xact("lw_miss", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b0, 3'b000, 1'b0);

    wait_cfg[0] = 1000; slv_data[0] = 32'h55AA_55AA;
    xact("lw_tmo", 1'b1, 1'b0, 32'h0001_0000, 32'h0, 18, 32'h0, 1'b1, 3'b001, 1'b1);

    slv_err[1] = 1'b1; slv_data[1] = 32'hDEAD_BEEF;
    xact("lw_serr", 1'b1, 1'b0, 32'h0001_0100, 32'h0, 3, 32'hDEAD_BEEF, 1'b1, 3'b010, 1'b1);
    slv_err[1] = 1'b0;

    xact("lw_dec", 1'b1, 1'b0, 32'h0001_0300, 32'h0, 1, 32'h0, 1'b1, 3'b000, 1'b1);

    // Illegal lw+sw is a write; followed back-to-back by another store.
    wait_cfg[0] = 1; slv_data[0] = 32'h1111_1111;
    xact("rw_both", 1'b1, 1'b1, 32'h0001_0008, 32'hCAFE_F00D, 4, 32'h0, 1'b0, 3'b001, 1'b1);
    xact("sw_b2b", 1'b0, 1'b1, 32'h0001_0210, 32'h0000_BEEF, 3, 32'h0, 1'b0, 3'b100, 1'b1);

    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
